// File: rtl/mod241_stream_seq.sv
`timescale 1ns/1ps
// Streams a wide operand MSB-first and reduces it mod 241 by Horner steps, one chunk per cycle.
// Optional length check against in_last is enabled by defining MOD241_SEQ_LAST_CHECK_EN.
module mod241_stream_seq #(
  parameter int CHUNK_W    = 8,
  parameter int NUM_CHUNKS = 25,
  parameter int CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [7:0]         res,
  output logic               err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]       state;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       res_r;

  logic        fire;
  logic        last_cnt;
  logic [11:0] t;
  logic [8:0]  u;
  logic [8:0]  v;
  logic [7:0]  acc_next;

  assign in_ready  = (state == S_ACCUM);
  assign res_valid = (state == S_RESULT);
  assign busy      = (state != S_IDLE);
  assign res       = res_r;
  assign fire      = in_valid & in_ready;
  assign last_cnt  = (cnt == CNT_W'(NUM_CHUNKS - 1));

  // 256 == 15 (mod 241), so each fold replaces the high part by 15x its value.
  always_comb begin
    t = ({4'd0, acc} << 4) - {4'd0, acc} + {4'd0, in_data};
    u = {1'b0, t[7:0]} + ({5'd0, t[11:8]} << 4) - {5'd0, t[11:8]};
    v = {1'b0, u[7:0]} + (u[8] ? 9'd15 : 9'd0);
    acc_next = (v >= 9'd241) ? 8'(v - 9'd241) : v[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= 8'd0;
      cnt   <= '0;
      res_r <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= 8'd0;
            cnt   <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (fire) begin
            acc <= acc_next;
            cnt <= cnt + CNT_W'(1);
            if (last_cnt) begin
              res_r <= acc_next;
              state <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MOD241_SEQ_LAST_CHECK_EN
  logic err_r;

  // Sticky across the operand; the operand length itself is never shortened by in_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err_r <= 1'b0;
    end else if (fire && (in_last != last_cnt)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  logic unused_last;
  assign unused_last = in_last;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod241_stream_seq.sv
`timescale 1ns/1ps
// Directed bench for mod241_stream_seq: hand-computed residues, handshake stalls and async reset abort.
module tb_mod241_stream_seq;

`ifdef MOD241_SEQ_LAST_CHECK_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res;
  logic       err;

  logic [7:0] op [25];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod241_stream_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] first, input logic [7:0] mid, input logic [7:0] last);
    for (int k = 0; k < 25; k++) op[k] = mid;
    op[0]  = first;
    op[24] = last;
  endtask

  task automatic start_op();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic feed(input bit gap, input int last_idx, input int n);
    int  i = 0;
    int  g = 0;
    bit  fired;
    while (i < n && g < 400) begin
      if (gap && g[0]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = op[i];
        in_last  = (i == last_idx);
      end
      if (i == n - 1 && n == 25 && in_valid) chk("pre_final_res_valid", res_valid, 0);
      fired = in_valid && in_ready;
      tick();
      if (fired) i++;
      g++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("feed_count", i, n);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("release_res_valid", res_valid, 0);
    chk("release_busy", busy, 0);
  endtask

  task automatic run_op(input bit gap, input int last_idx, input logic [7:0] exp_res, input bit exp_err);
    start_op();
    feed(gap, last_idx, 25);
    chk("res_valid_latency", res_valid, 1);
    chk("res_value", res, exp_res);
    chk("err_value", err, exp_err);
    chk("result_in_ready", in_ready, 0);
    release_res();
    chk("res_holds", res, exp_res);
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // in_valid in IDLE must not start anything
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    tick();
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    fill(8'h00, 8'h00, 8'h00);
    run_op(1'b0, 24, 8'd0, 1'b0);

    fill(8'h01, 8'h00, 8'h00);
    run_op(1'b0, 24, 8'd1, 1'b0);

    fill(8'h00, 8'h00, 8'hFF);
    run_op(1'b0, 24, 8'd14, 1'b0);

    fill(8'h00, 8'h00, 8'hF1);
    run_op(1'b0, 24, 8'd0, 1'b0);

    fill(8'hFF, 8'hFF, 8'hFF);
    run_op(1'b1, 24, 8'd14, 1'b0);

    // 2^192 + 0xF0 -> 1 + 240 = 241 -> 0
    fill(8'h01, 8'h00, 8'hF0);
    run_op(1'b0, 24, 8'd0, 1'b0);

    // Stall the result for 10 cycles; a start here must be ignored
    fill(8'h00, 8'h00, 8'hFF);
    start_op();
    feed(1'b0, 24, 25);
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res", res, 14);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    start = 1'b0;
    release_res();

    // Async reset mid-operand
    fill(8'hFF, 8'hFF, 8'hFF);
    start_op();
    feed(1'b0, 24, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res", res, 0);
    chk("abort_err", err, 0);
    chk("abort_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    tick();
    fill(8'h01, 8'h00, 8'h00);
    run_op(1'b0, 24, 8'd1, 1'b0);

    // Early in_last on chunk 10, then a clean operand clears the flag
    fill(8'h00, 8'h00, 8'hFF);
    run_op(1'b0, 10, 8'd14, LAST_EN);
    run_op(1'b0, 24, 8'd14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
